// File: rtl/clk_div_int_pkg.sv
// Shared definitions for the integer clock divider: mode encoding, limits and
// the phase-length arithmetic used to split a ratio into low/high phases.
package clk_div_int_pkg;

    localparam int RATIO_WIDTH_DEF = 8;
    localparam int MIN_DIV_RATIO   = 2;

    typedef enum logic {
        BYPASS = 1'b0,
        DIVIDE = 1'b1
    } mode_e;

    // Odd ratios put the extra cycle in the low phase.
    function automatic int low_len(input int ratio);
        return (ratio + 1) / 2;
    endfunction

    function automatic int high_len(input int ratio);
        return ratio / 2;
    endfunction

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter: counts reference cycles within the current phase and pulses
// toggle on the last cycle of that phase.
module clk_div_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [W-1:0] phase_len,
    output logic         toggle
);

    logic [W-1:0] cnt_r;

    // Terminal-count compare against the length of the phase in progress.
    always_comb begin
        toggle = run && (cnt_r == (phase_len - W'(1)));
    end

    // Counter clears whenever the divider is idle or a phase completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!run) begin
            cnt_r <= '0;
        end else if (toggle) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

endmodule

// File: rtl/clk_div_int.sv
// Integer clock divider with bypass; ratio changes take effect only at the
// end of a full divided period so no truncated phase is ever emitted.
module clk_div_int
    import clk_div_int_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic [RATIO_WIDTH-1:0] o_ratio_active,
    output logic                   o_div_mode
);

    logic [RATIO_WIDTH-1:0] ratio_r;
    logic                   div_r;
    mode_e                  mode_r;

    logic                   run_s;
    logic                   toggle_s;
    logic                   boundary_s;
    logic                   ratio_ok_s;
    logic [RATIO_WIDTH-1:0] phase_len_s;

    // Phase length follows the divided-clock level; boundary = end of high phase.
    always_comb begin
        run_s       = (mode_r == DIVIDE) && i_clk_en;
        ratio_ok_s  = (i_div_ratio >= RATIO_WIDTH'(MIN_DIV_RATIO));
        boundary_s  = toggle_s && div_r;
        if (div_r) begin
            phase_len_s = RATIO_WIDTH'(high_len(int'(ratio_r)));
        end else begin
            phase_len_s = RATIO_WIDTH'(low_len(int'(ratio_r)));
        end
    end

    clk_div_phase_cnt #(
        .W(RATIO_WIDTH)
    ) u_phase_cnt (
        .clk       (i_ref_clk),
        .rst_n     (i_rst_n),
        .run       (run_s),
        .phase_len (phase_len_s),
        .toggle    (toggle_s)
    );

    // Mode FSM with shadow ratio register and divided-clock level.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ratio_r <= '0;
            div_r   <= 1'b0;
            mode_r  <= BYPASS;
        end else begin
            case (mode_r)
                BYPASS: begin
                    ratio_r <= i_div_ratio;
                    div_r   <= 1'b0;
                    if (i_clk_en && ratio_ok_s) begin
                        mode_r <= DIVIDE;
                    end else begin
                        mode_r <= BYPASS;
                    end
                end
                DIVIDE: begin
                    if (!i_clk_en) begin
                        // Disable wins over a coincident period boundary.
                        div_r  <= 1'b0;
                        mode_r <= BYPASS;
                    end else if (boundary_s) begin
                        ratio_r <= i_div_ratio;
                        div_r   <= 1'b0;
                        mode_r  <= ratio_ok_s ? DIVIDE : BYPASS;
                    end else if (toggle_s) begin
                        div_r <= ~div_r;
                    end else begin
                        div_r <= div_r;
                    end
                end
                default: begin
                    ratio_r <= '0;
                    div_r   <= 1'b0;
                    mode_r  <= BYPASS;
                end
            endcase
        end
    end

    assign o_div_clk      = (mode_r == DIVIDE) ? div_r : i_ref_clk;
    assign o_ratio_active = ratio_r;
    assign o_div_mode     = (mode_r == DIVIDE);

endmodule
